// File: rtl/tetris_field_pkg.sv
// Shared types and defaults for the tetris playfield engine.
//   fop_e    : command opcodes carried on cmd_op_i
//   fstate_e : engine sequencing states
//   cell_idx : flat index of cell (r,c) in occupancy / write-mask vectors
package tetris_field_pkg;

   localparam int unsigned DEF_ROWS       = 20;
   localparam int unsigned DEF_COLS       = 10;
   localparam int unsigned DEF_COLOR_W    = 3;
   localparam int unsigned DEF_GARB_COLOR = 7;

   typedef enum logic [1:0] {
      FOP_CLEAR   = 2'd0,
      FOP_APPEND  = 2'd1,
      FOP_SWEEP   = 2'd2,
      FOP_GARBAGE = 2'd3
   } fop_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SCAN,
      ST_FILL,
      ST_GARB,
      ST_DONE
   } fstate_e;

   function automatic int unsigned cell_idx(input int unsigned r, input int unsigned c,
                                            input int unsigned cols);
      return r * cols + c;
   endfunction

endpackage

// File: rtl/tetris_field_engine_block_stamp.sv
// Combinational 4x4 shape placement.
//   blk_data_i : shape bits, bit i*4+j = shape row i, col j
//   blk_x_i    : signed column of shape col 0
//   blk_y_i    : signed row of shape row 0
//   mask_o     : per-cell write mask, bit r*COLS+c; off-field targets are dropped
//   above_o    : some set shape bit lands above row 0
module block_stamp
   import tetris_field_pkg::*;
#(
   parameter int unsigned ROWS = DEF_ROWS,
   parameter int unsigned COLS = DEF_COLS
) (
   input  logic [15:0]                  blk_data_i,
   input  logic signed [$clog2(COLS):0] blk_x_i,
   input  logic signed [$clog2(ROWS):0] blk_y_i,
   output logic [ROWS*COLS-1:0]         mask_o,
   output logic                         above_o
);

   localparam int unsigned XW = $clog2(COLS) + 1;
   localparam int unsigned YW = $clog2(ROWS) + 1;

   logic [3:0] row_above;

   // shape row i lands above the field when y + i < 0, i.e. y < -i
   for (genvar i = 0; i < 4; i++) begin : g_above
      localparam logic signed [YW-1:0] LIM = YW'(-i);
      assign row_above[i] = (|blk_data_i[i*4 +: 4]) && (blk_y_i < LIM);
   end
   assign above_o = |row_above;

   // each cell asks whether any shape bit targets it; this keeps all
   // indices constant instead of decoding a variable target position
   for (genvar r = 0; r < ROWS; r++) begin : g_row
      for (genvar c = 0; c < COLS; c++) begin : g_col
         logic [15:0] hit;
         for (genvar i = 0; i < 4; i++) begin : g_si
            for (genvar j = 0; j < 4; j++) begin : g_sj
               localparam logic signed [YW-1:0] RY = YW'(r - i);
               localparam logic signed [XW-1:0] XC = XW'(c - j);
               assign hit[i*4+j] = blk_data_i[i*4+j] && (blk_y_i == RY) && (blk_x_i == XC);
            end
         end
         assign mask_o[cell_idx(r, c, COLS)] = |hit;
      end
   end

endmodule

// File: rtl/tetris_field_engine.sv
// Tetris playfield store and update engine.
//   clk_i, rst_n_i        : clock, async active-low reset
//   cmd_valid_i/ready_o   : command handshake, accepted when both high
//   cmd_op_i              : CLEAR / APPEND / SWEEP / GARBAGE
//   blk_*_i               : shape, colour and signed position for APPEND
//   garb_rows_i/hole_i    : garbage row count and hole column for GARBAGE
//   done_o                : one-cycle completion pulse
//   lines_cleared_o       : rows removed by the last SWEEP
//   full_mask_o           : full-row mask captured at SWEEP accept
//   topout_o              : sticky overflow flag
//   field_o, occ_o        : colour field and occupancy views
module tetris_field_engine
   import tetris_field_pkg::*;
#(
   parameter int unsigned ROWS       = DEF_ROWS,
   parameter int unsigned COLS       = DEF_COLS,
   parameter int unsigned COLOR_W    = DEF_COLOR_W,
   parameter int unsigned GARB_COLOR = DEF_GARB_COLOR
) (
   input  logic                          clk_i,
   input  logic                          rst_n_i,
   input  logic                          cmd_valid_i,
   output logic                          cmd_ready_o,
   input  logic [1:0]                    cmd_op_i,
   input  logic [15:0]                   blk_data_i,
   input  logic [COLOR_W-1:0]            blk_color_i,
   input  logic signed [$clog2(COLS):0]  blk_x_i,
   input  logic signed [$clog2(ROWS):0]  blk_y_i,
   input  logic [2:0]                    garb_rows_i,
   input  logic [$clog2(COLS)-1:0]       garb_hole_i,
   output logic                          done_o,
   output logic [$clog2(ROWS+1)-1:0]     lines_cleared_o,
   output logic [ROWS-1:0]               full_mask_o,
   output logic                          topout_o,
   output logic [ROWS*COLS*COLOR_W-1:0]  field_o,
   output logic [ROWS*COLS-1:0]          occ_o
);

   localparam int unsigned RW = $clog2(ROWS);
   localparam int unsigned CW = $clog2(ROWS+1);
   localparam int unsigned HW = $clog2(COLS);
   localparam logic [COLOR_W-1:0] GCOL = COLOR_W'(GARB_COLOR);

   typedef logic [COLS-1:0][COLOR_W-1:0] row_t;

   fstate_e          state_q, state_d;
   row_t [ROWS-1:0]  field_q, field_d;
   logic [RW-1:0]    rd_q, rd_d, wr_q, wr_d;
   logic [CW-1:0]    cnt_q, cnt_d, lines_q, lines_d;
   logic [ROWS-1:0]  fmask_q, fmask_d;
   logic [2:0]       garb_q, garb_d;
   logic [HW-1:0]    hole_q, hole_d;
   logic             top_q, top_d;

   logic [ROWS*COLS-1:0] stamp_mask;
   logic                 stamp_above;
   logic [ROWS*COLS-1:0] occ;
   logic [ROWS-1:0]      row_full;
   row_t [ROWS-1:0]      stamp_field, garb_field;

   block_stamp #(
      .ROWS (ROWS),
      .COLS (COLS)
   ) u_stamp (
      .blk_data_i (blk_data_i),
      .blk_x_i    (blk_x_i),
      .blk_y_i    (blk_y_i),
      .mask_o     (stamp_mask),
      .above_o    (stamp_above)
   );

   // per-cell views: occupancy, stamped field, field shifted up with a garbage bottom row
   for (genvar r = 0; r < ROWS; r++) begin : g_row
      for (genvar c = 0; c < COLS; c++) begin : g_col
         localparam int unsigned K = cell_idx(r, c, COLS);
         localparam logic [HW-1:0] CI = HW'(c);
         assign occ[K] = |field_q[r][c];
         assign stamp_field[r][c] = (stamp_mask[K] && (blk_color_i != '0)) ? blk_color_i
                                                                            : field_q[r][c];
         if (r == ROWS - 1) begin : g_bot
            assign garb_field[r][c] = (hole_q == CI) ? '0 : GCOL;
         end else begin : g_up
            assign garb_field[r][c] = field_q[r+1][c];
         end
      end
      assign row_full[r] = &occ[r*COLS +: COLS];
   end

   always_comb begin
      state_d = state_q;
      field_d = field_q;
      rd_d    = rd_q;
      wr_d    = wr_q;
      cnt_d   = cnt_q;
      lines_d = lines_q;
      fmask_d = fmask_q;
      garb_d  = garb_q;
      hole_d  = hole_q;
      top_d   = top_q;
      unique case (state_q)
         ST_IDLE: begin
            if (cmd_valid_i) begin
               unique case (fop_e'(cmd_op_i))
                  FOP_CLEAR: begin
                     field_d = '0;
                     top_d   = 1'b0;
                     state_d = ST_DONE;
                  end
                  FOP_APPEND: begin
                     field_d = stamp_field;
                     if (stamp_above) top_d = 1'b1;
                     state_d = ST_DONE;
                  end
                  FOP_SWEEP: begin
                     fmask_d = row_full;
                     lines_d = '0;
                     rd_d    = RW'(ROWS - 1);
                     wr_d    = RW'(ROWS - 1);
                     cnt_d   = '0;
                     state_d = ST_SCAN;
                  end
                  FOP_GARBAGE: begin
                     garb_d  = garb_rows_i;
                     hole_d  = garb_hole_i;
                     state_d = (garb_rows_i == 3'd0) ? ST_DONE : ST_GARB;
                  end
                  default: ;
               endcase
            end
         end
         // rd walks every row bottom-up; wr trails it and only advances past kept rows
         ST_SCAN: begin
            if (row_full[rd_q]) begin
               cnt_d = cnt_q + CW'(1);
            end else begin
               if (wr_q != rd_q) field_d[wr_q] = field_q[rd_q];
               wr_d = wr_q - RW'(1);
            end
            rd_d = rd_q - RW'(1);
            if (rd_q == '0) state_d = (cnt_d != '0) ? ST_FILL : ST_DONE;
         end
         // wr never wraps below zero: the row-0 pass hands over to DONE
         ST_FILL: begin
            field_d[wr_q] = '0;
            wr_d = wr_q - RW'(1);
            if (wr_q == '0) begin
               lines_d = cnt_q;
               state_d = ST_DONE;
            end
         end
         ST_GARB: begin
            if (|field_q[0]) top_d = 1'b1;
            field_d = garb_field;
            garb_d  = garb_q - 3'd1;
            if (garb_q == 3'd1) state_d = ST_DONE;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= ST_IDLE;
         field_q <= '0;
         rd_q    <= '0;
         wr_q    <= '0;
         cnt_q   <= '0;
         lines_q <= '0;
         fmask_q <= '0;
         garb_q  <= '0;
         hole_q  <= '0;
         top_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         field_q <= field_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         cnt_q   <= cnt_d;
         lines_q <= lines_d;
         fmask_q <= fmask_d;
         garb_q  <= garb_d;
         hole_q  <= hole_d;
         top_q   <= top_d;
      end
   end

   assign cmd_ready_o     = (state_q == ST_IDLE);
   assign done_o          = (state_q == ST_DONE);
   assign lines_cleared_o = lines_q;
   assign full_mask_o     = fmask_q;
   assign topout_o        = top_q;
   assign field_o         = field_q;
   assign occ_o           = occ;

endmodule

// File: tb/tb_tetris_field_engine.sv
module tb_tetris_field_engine;
   import tetris_field_pkg::*;

   localparam int ROWS = 20;
   localparam int COLS = 10;
   localparam int CLW  = 3;
   localparam int GC   = 7;
   localparam int XW   = $clog2(COLS) + 1;
   localparam int YW   = $clog2(ROWS) + 1;
   localparam int HW   = $clog2(COLS);
   localparam int LW   = $clog2(ROWS + 1);

   logic                     clk = 1'b0;
   logic                     rst_n = 1'b0;
   logic                     cmd_valid = 1'b0;
   logic                     cmd_ready;
   logic [1:0]               cmd_op = '0;
   logic [15:0]              blk_data = '0;
   logic [CLW-1:0]           blk_color = '0;
   logic signed [XW-1:0]     blk_x = '0;
   logic signed [YW-1:0]     blk_y = '0;
   logic [2:0]               garb_rows = '0;
   logic [HW-1:0]            garb_hole = '0;
   logic                     done;
   logic [LW-1:0]            lines_cleared;
   logic [ROWS-1:0]          full_mask;
   logic                     topout;
   logic [ROWS*COLS*CLW-1:0] field;
   logic [ROWS*COLS-1:0]     occ;

   always #5 clk = ~clk;

   tetris_field_engine #(
      .ROWS       (ROWS),
      .COLS       (COLS),
      .COLOR_W    (CLW),
      .GARB_COLOR (GC)
   ) dut (
      .clk_i           (clk),
      .rst_n_i         (rst_n),
      .cmd_valid_i     (cmd_valid),
      .cmd_ready_o     (cmd_ready),
      .cmd_op_i        (cmd_op),
      .blk_data_i      (blk_data),
      .blk_color_i     (blk_color),
      .blk_x_i         (blk_x),
      .blk_y_i         (blk_y),
      .garb_rows_i     (garb_rows),
      .garb_hole_i     (garb_hole),
      .done_o          (done),
      .lines_cleared_o (lines_cleared),
      .full_mask_o     (full_mask),
      .topout_o        (topout),
      .field_o         (field),
      .occ_o           (occ)
   );

   typedef struct {
      int op; int data; int color; int x; int y; int grows; int hole;
      int exp_lat; int exp_top; int exp_lines; int exp_mask;  // -1 = not checked
   } vec_t;

   int model[ROWS][COLS];
   bit m_top = 0;
   int m_lines = 0;
   int m_mask = 0;
   int total = 0;
   int bad = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_field(input string name);
      int er = -1, ec = -1, ea = 0, ev = 0;
      bit occ_bad = 0;
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++) begin
            int a;
            a = int'(field[(r*COLS+c)*CLW +: CLW]);
            if (a != model[r][c] && er < 0) begin er = r; ec = c; ea = a; ev = model[r][c]; end
            if (occ[r*COLS+c] != (model[r][c] != 0)) occ_bad = 1;
         end
      total++;
      if (er >= 0) begin
         bad++;
         $display("FAIL %s field cell (%0d,%0d): got %0d expected %0d", name, er, ec, ea, ev);
      end
      total++;
      if (occ_bad) begin
         bad++;
         $display("FAIL %s occ: got inconsistent expected occupancy of model field", name);
      end
   endtask

   task automatic model_reset();
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++) model[r][c] = 0;
      m_top = 0; m_lines = 0; m_mask = 0;
   endtask

   // Behavioural reference: whole-field operations on an int array.
   task automatic model_cmd(input vec_t v, output int lat);
      case (v.op)
         0: begin
            for (int r = 0; r < ROWS; r++)
               for (int c = 0; c < COLS; c++) model[r][c] = 0;
            m_top = 0;
            lat = 1;
         end
         1: begin
            for (int i = 0; i < 4; i++)
               for (int j = 0; j < 4; j++)
                  if ((v.data >> (i*4+j)) & 1) begin
                     int r, c;
                     r = v.y + i; c = v.x + j;
                     if (r < 0) m_top = 1;
                     else if (r < ROWS && c >= 0 && c < COLS && v.color != 0) model[r][c] = v.color;
                  end
            lat = 1;
         end
         2: begin
            int tmp[ROWS][COLS];
            int dst;
            m_mask = 0; m_lines = 0; dst = ROWS - 1;
            for (int r = 0; r < ROWS; r++) begin
               bit full = 1;
               for (int c = 0; c < COLS; c++) if (model[r][c] == 0) full = 0;
               if (full) m_mask |= (1 << r);
               for (int c = 0; c < COLS; c++) tmp[r][c] = 0;
            end
            for (int r = ROWS - 1; r >= 0; r--) begin
               if ((m_mask >> r) & 1) m_lines++;
               else begin tmp[dst] = model[r]; dst--; end
            end
            model = tmp;
            lat = ROWS + m_lines + 1;
         end
         default: begin
            for (int k = 0; k < v.grows; k++) begin
               for (int c = 0; c < COLS; c++) if (model[0][c] != 0) m_top = 1;
               for (int r = 0; r < ROWS - 1; r++) model[r] = model[r+1];
               for (int c = 0; c < COLS; c++) model[ROWS-1][c] = (c == v.hole) ? 0 : GC;
            end
            lat = v.grows + 1;
         end
      endcase
   endtask

   task automatic drive(input vec_t v);
      cmd_op    = 2'(v.op);
      blk_data  = 16'(v.data);
      blk_color = CLW'(v.color);
      blk_x     = XW'(v.x);
      blk_y     = YW'(v.y);
      garb_rows = 3'(v.grows);
      garb_hole = HW'(v.hole);
   endtask

   // Starts and ends on a falling edge.
   task automatic run_cmd(input vec_t v, input string tag);
      int lat_exp, lat, guard;
      bit seen;
      guard = 0; seen = 0; lat = 0;
      while (!cmd_ready && guard < 50) begin @(negedge clk); guard++; end
      drive(v);
      cmd_valid = 1'b1;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      model_cmd(v, lat_exp);
      for (int k = 1; k <= 3 * ROWS && !seen; k++) begin
         @(negedge clk);
         if (done) begin seen = 1; lat = k; end
      end
      chk({tag, " latency"}, lat, lat_exp);
      if (v.exp_lat > 0) chk({tag, " table latency"}, lat, v.exp_lat);
      chk({tag, " ready in done"}, cmd_ready, 0);
      chk({tag, " topout"}, topout, m_top);
      chk({tag, " lines"}, lines_cleared, m_lines);
      chk({tag, " full_mask"}, full_mask, m_mask);
      chk_field(tag);
      if (v.exp_top >= 0) chk({tag, " table topout"}, topout, v.exp_top);
      if (v.exp_lines >= 0) chk({tag, " table lines"}, lines_cleared, v.exp_lines);
      if (v.exp_mask >= 0) chk({tag, " table mask"}, full_mask, v.exp_mask);
      @(negedge clk);
      chk({tag, " done one cycle"}, done, 0);
      chk({tag, " ready after done"}, cmd_ready, 1);
   endtask

   function automatic vec_t mk(input int op, input int data, input int color, input int x,
                               input int y, input int grows, input int hole, input int lat,
                               input int top, input int lines, input int mask);
      vec_t v;
      v.op = op; v.data = data; v.color = color; v.x = x; v.y = y;
      v.grows = grows; v.hole = hole; v.exp_lat = lat; v.exp_top = top;
      v.exp_lines = lines; v.exp_mask = mask;
      return v;
   endfunction

   function automatic vec_t rnd_vec();
      vec_t v;
      int sel;
      v = mk(0, 0, 0, 0, 0, 0, 0, -1, -1, -1, -1);
      sel = int'($urandom_range(0, 9));
      v.op = (sel == 0) ? 0 : (sel <= 5) ? 1 : (sel <= 7) ? 2 : 3;
      v.data = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 65535))
                                            : (($urandom_range(0, 1) == 1) ? 'h000F : 'h0FFF);
      v.color = int'($urandom_range(0, 7));
      v.x = int'($urandom_range(0, COLS + 2)) - 3;
      v.y = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, ROWS + 2)) - 3
                                         : int'($urandom_range(ROWS - 6, ROWS - 1));
      v.grows = int'($urandom_range(0, 4));
      v.hole = int'($urandom_range(0, 15));
      return v;
   endfunction

   vec_t tbl[$];

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      model_reset();
      // directed table: {op,data,color,x,y,grows,hole, lat,top,lines,mask}
      tbl.push_back(mk(0, 'h0000, 0,  0,  0, 0,  0,  1, 0, -1, -1));
      tbl.push_back(mk(1, 'h0033, 3, -1, 18, 0,  0,  1, 0, -1, -1));
      tbl.push_back(mk(1, 'h000F, 2,  1, 19, 0,  0,  1, 0, -1, -1));
      tbl.push_back(mk(1, 'h000F, 2,  5, 19, 0,  0,  1, 0, -1, -1));
      tbl.push_back(mk(1, 'h000F, 2,  6, 19, 0,  0,  1, 0, -1, -1));
      tbl.push_back(mk(1, 'h000F, 4,  0, 17, 0,  0,  1, 0, -1, -1));
      tbl.push_back(mk(1, 'h000F, 4,  4, 17, 0,  0,  1, 0, -1, -1));
      tbl.push_back(mk(1, 'h000F, 4,  6, 17, 0,  0,  1, 0, -1, -1));
      tbl.push_back(mk(1, 'h0001, 5,  2, 18, 0,  0,  1, 0, -1, -1));
      tbl.push_back(mk(1, 'h0001, 6,  5, 16, 0,  0,  1, 0, -1, -1));
      tbl.push_back(mk(2, 'h0000, 0,  0,  0, 0,  0, 23, 0,  2, 'hA0000));
      tbl.push_back(mk(1, 'h0001, 1,  0, -1, 0,  0,  1, 1, -1, -1));
      tbl.push_back(mk(2, 'h0000, 0,  0,  0, 0,  0, 21, 1,  0, 0));
      tbl.push_back(mk(0, 'h0000, 0,  0,  0, 0,  0,  1, 0,  0, 0));
      tbl.push_back(mk(1, 'h0001, 4,  3,  3, 0,  0,  1, 0, -1, -1));
      tbl.push_back(mk(3, 'h0000, 0,  0,  0, 3,  4,  4, 0, -1, -1));
      tbl.push_back(mk(3, 'h0000, 0,  0,  0, 1,  4,  2, 1, -1, -1));
      tbl.push_back(mk(0, 'h0000, 0,  0,  0, 0,  0,  1, 0, -1, -1));
      tbl.push_back(mk(1, 'h00F0, 0,  0, -2, 0,  0,  1, 1, -1, -1));
      tbl.push_back(mk(3, 'h0000, 0,  0,  0, 2, 12,  3, 1, -1, -1));
      tbl.push_back(mk(1, 'hFFFF, 5,  8, 17, 0,  0,  1, 1, -1, -1));
      tbl.push_back(mk(2, 'h0000, 0,  0,  0, 0,  0, 23, 1,  2, 'hC0000));
      tbl.push_back(mk(3, 'h0000, 0,  0,  0, 0,  0,  1, 1, -1, -1));

      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset ready", cmd_ready, 1);
      chk("reset done", done, 0);
      chk("reset topout", topout, 0);
      chk("reset lines", lines_cleared, 0);
      chk("reset mask", full_mask, 0);
      chk("reset occ", occ, 0);
      rst_n = 1'b1;
      @(negedge clk);

      foreach (tbl[i]) run_cmd(tbl[i], $sformatf("vec%0d", i));

      for (int n = 0; n < 60; n++) run_cmd(rnd_vec(), $sformatf("rnd%0d", n));

      // reset in the middle of a sweep
      run_cmd(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, -1, -1), "rs_clr");
      run_cmd(mk(1, 'h000F, 2, 0, 19, 0, 0, 1, -1, -1, -1), "rs_a");
      run_cmd(mk(1, 'h000F, 2, 4, 19, 0, 0, 1, -1, -1, -1), "rs_b");
      run_cmd(mk(1, 'h000F, 2, 6, 19, 0, 0, 1, -1, -1, -1), "rs_c");
      run_cmd(mk(1, 'h0001, 3, 0, -1, 0, 0, 1, 1, -1, -1), "rs_top");
      run_cmd(mk(1, 'h00FF, 5, 3, 18, 0, 0, 1, -1, -1, -1), "rs_d");
      run_cmd(mk(2, 0, 0, 0, 0, 0, 0, 22, 1, 1, 'h80000), "rs_sweep");
      run_cmd(mk(1, 'h000F, 2, 0, 18, 0, 0, 1, -1, -1, -1), "rs_e");
      drive(mk(2, 0, 0, 0, 0, 0, 0, -1, -1, -1, -1));
      cmd_valid = 1'b1;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      #1;
      model_reset();
      chk("midscan ready", cmd_ready, 1);
      chk("midscan done", done, 0);
      chk("midscan topout", topout, 0);
      chk("midscan lines", lines_cleared, 0);
      chk("midscan mask", full_mask, 0);
      chk_field("midscan");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_cmd(mk(2, 0, 0, 0, 0, 0, 0, 21, 0, 0, 0), "post_rst_sweep");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
